dma_controller: RTL
===================

// Module: dma_controller
// PURPOSE
//  Bus-master DMA engine that moves data from external_device into memory.
//  - On a device interrupt the CPU issues a DMA command with a base address and a length.
//  - The engine requests the bus (BR/BG), reads each 4-word block by driving the device
//    offset, and writes the blocks to memory.
//  - It then releases the bus and pulses dma_end so the CPU can resume.
//  Sits between external_device (upstream) and the memory write port / CPU bus arbiter.
// PARAMETERS
//  WORD_SIZE       16  bits per memory word
//  BLOCK_WORDS      4  words per device block (device data width = BLOCK_WORDS*WORD_SIZE)
//  MAX_BLOCKS       3  blocks the device holds (offsets 0..MAX_BLOCKS-1)
//  DEVICE_BIT_LEN   2  width of the device offset bus
//  ADDR_WIDTH      16  memory word-address width
// PORTS
//  clk          in   1     rising-edge clock
//  reset_n      in   1     asynchronous active-low reset
//  cmd_valid    in   1     CPU command strobe, 1 cycle; honoured only in IDLE
//  cmd_addr     in   ADDR_WIDTH   memory base word address
//  cmd_length   in   ADDR_WIDTH   transfer length in words
//  BG           in   1     bus grant from CPU
//  BR           out  1     bus request to CPU
//  offset       out  DEVICE_BIT_LEN  block index to external_device
//  dev_data     in   BLOCK_WORDS*WORD_SIZE  block data from external_device (combinational from offset)
//  mem_write    out  1     memory write request, held until mem_ready
//  mem_addr     out  ADDR_WIDTH   memory word address of the block
//  mem_wdata    out  BLOCK_WORDS*WORD_SIZE  block to write
//  mem_ready    in   1     memory accepted the block this cycle
//  busy         out  1     high from command acceptance until dma_end
//  dma_end      out  1     1-cycle completion interrupt to CPU
// BEHAVIOUR
//  Reset values (async, reset_n=0): state=IDLE, BR=0, mem_write=0, mem_addr=0,
//  mem_wdata=0, dma_end=0, busy=0, offset=2'b11 (idle offset; device returns z).
//  Command latch in IDLE: base<=cmd_addr.
//   - nblk = ceil(cmd_length/BLOCK_WORDS), clamped to MAX_BLOCKS.
//   - blk <= 0.
//  States:
//   - IDLE: on cmd_valid with nblk>0 -> REQ, busy=1. With nblk==0 -> DONE directly, BR never raised.
//   - REQ: BR=1; wait for BG; BG=1 -> FETCH.
//   - FETCH: 1 cycle; offset=blk; buffer<=dev_data at the clock edge -> WRITE.
//   - WRITE: mem_write=1, mem_addr=base+blk*BLOCK_WORDS (mod 2^ADDR_WIDTH), mem_wdata=buffer.
//     Hold all three until mem_ready. On mem_ready:
//       - blk+1==nblk -> DONE
//       - else if BG -> FETCH with blk+1
//       - else -> REQ with blk+1
//   - DONE: BR=0, dma_end=1 for exactly one cycle, busy=0 next cycle -> IDLE.
//  BR is asserted in REQ, FETCH and WRITE; it drops in the DONE cycle.
//  BG withdrawn during WRITE: the current block write still completes; the next block waits in REQ.
//  BG withdrawn during FETCH: FETCH completes (device read is not a bus cycle).
//  cmd_valid outside IDLE: ignored. No queueing and no error flag.
//  Latency, zero-wait memory with BG granted in the same cycle as BR:
//   - 1 (REQ) + 2 cycles per block (FETCH + WRITE) + 1 (DONE).
//   - 3 blocks: dma_end is high in cycle 8 after command acceptance.
//  offset returns to 2'b11 in every state except FETCH.
//  dev_interrupt is not an input: the CPU services the device interrupt and issues the command.
// STRUCTURE
//  Shared package/header: WORD_SIZE, BLOCK_WORDS, DEVICE_BIT_LEN, MAX_BLOCKS, the idle offset
//  constant and the state encodings, so external_device, the CPU and this block stay in agreement.
//  Single module; one FSM plus blk counter plus block buffer. No sub-module.
// TESTING
//  1. cmd addr=0x01F4, length=12, BG granted the cycle after BR, mem_ready immediate:
//     - writes 0x01F4, 0x01F8, 0x01FC with storage blocks 0,1,2;
//     - BR falls and dma_end pulses once.
//  2. length=5: exactly 2 blocks written (0x01F4, 0x01F8); length=0: dma_end with BR never high.
//  3. mem_ready delayed 3 cycles per block: mem_write/addr/wdata held stable; no skipped
//     or duplicated block.
//  4. BG dropped during block 1 WRITE: block 1 completes; engine waits in REQ with BR=1;
//     BG re-asserted -> block 2 written to 0x01FC.
//  5. Second cmd_valid while busy: ignored, single transfer only.
//     reset_n low mid-WRITE: all outputs at reset values immediately; offset=3.
//  6. Base 0xFFFC, length 12: addresses wrap to 0xFFFC, 0x0000, 0x0004.

Source files
------------

// File: rtl/dma_controller_pkg.sv
// Shared constants for the DMA engine, external_device and CPU model: widths, idle offset,
// state encodings and the block-count / block-address helpers.
package dma_controller_pkg;

    localparam int unsigned WORD_SIZE      = 16;
    localparam int unsigned BLOCK_WORDS    = 4;
    localparam int unsigned MAX_BLOCKS     = 3;
    localparam int unsigned DEVICE_BIT_LEN = 2;
    localparam int unsigned ADDR_WIDTH     = 16;
    localparam int unsigned BLOCK_BITS     = BLOCK_WORDS * WORD_SIZE;

    typedef logic [ADDR_WIDTH-1:0]     addr_t;
    typedef logic [ADDR_WIDTH:0]       len_ext_t;
    typedef logic [BLOCK_BITS-1:0]     block_t;
    typedef logic [DEVICE_BIT_LEN-1:0] offset_t;

    // Device answers with high-impedance data on this offset.
    localparam offset_t IDLE_OFFSET = 2'b11;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_REQ   = 3'd1;
    localparam logic [2:0] ST_FETCH = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Blocks to move for a word count: rounded up, then clamped to what the device holds.
    function automatic offset_t calc_nblk(input addr_t len);
        len_ext_t blocks;
        blocks = (len_ext_t'(len) + len_ext_t'(BLOCK_WORDS - 1)) / len_ext_t'(BLOCK_WORDS);
        if (blocks > len_ext_t'(MAX_BLOCKS)) begin
            return offset_t'(MAX_BLOCKS);
        end
        return offset_t'(blocks);
    endfunction

    function automatic addr_t block_addr(input addr_t base, input offset_t blk);
        return base + addr_t'(blk) * addr_t'(BLOCK_WORDS);
    endfunction

endpackage

// File: rtl/dma_controller_if.sv
// Command, bus-arbitration, device and memory-write signals of the DMA engine.
interface dma_controller_if;
    import dma_controller_pkg::*;

    logic    cmd_valid;
    addr_t   cmd_addr;
    addr_t   cmd_length;
    logic    BG;
    logic    BR;
    offset_t offset;
    block_t  dev_data;
    logic    mem_write;
    addr_t   mem_addr;
    block_t  mem_wdata;
    logic    mem_ready;
    logic    busy;
    logic    dma_end;

    modport master (
        input  cmd_valid, cmd_addr, cmd_length, BG, dev_data, mem_ready,
        output BR, offset, mem_write, mem_addr, mem_wdata, busy, dma_end
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_length, BG, dev_data, mem_ready,
        input  BR, offset, mem_write, mem_addr, mem_wdata, busy, dma_end
    );

endinterface

// File: rtl/dma_controller.sv
// Bus-master DMA engine: on a CPU command it requests the bus, copies up to MAX_BLOCKS
// device blocks into memory one block per write, then releases the bus and pulses dma_end.
module dma_controller
    import dma_controller_pkg::*;
(
    input logic              clk,
    input logic              reset_n,
    dma_controller_if.master bus
);

    logic [2:0] r_state, w_state;
    addr_t      r_base, w_base;
    offset_t    r_nblk, w_nblk;
    offset_t    r_blk, w_blk;
    block_t     r_buffer, w_buffer;
    addr_t      r_mem_addr, w_mem_addr;
    logic       r_busy, w_busy;

    offset_t    w_cmd_nblk;
    logic       w_last_blk;

    assign w_cmd_nblk = calc_nblk(bus.cmd_length);
    assign w_last_blk = ((r_blk + offset_t'(1)) == r_nblk);

    always_comb begin
        w_state    = r_state;
        w_base     = r_base;
        w_nblk     = r_nblk;
        w_blk      = r_blk;
        w_buffer   = r_buffer;
        w_mem_addr = r_mem_addr;
        w_busy     = r_busy;

        case (r_state)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    w_base  = bus.cmd_addr;
                    w_nblk  = w_cmd_nblk;
                    w_blk   = '0;
                    w_busy  = 1'b1;
                    // A zero-length command completes without ever touching the bus.
                    w_state = (w_cmd_nblk != '0) ? ST_REQ : ST_DONE;
                end
            end
            ST_REQ: begin
                if (bus.BG) begin
                    w_state = ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_buffer   = bus.dev_data;
                w_mem_addr = block_addr(r_base, r_blk);
                w_state    = ST_WRITE;
            end
            ST_WRITE: begin
                if (bus.mem_ready) begin
                    if (w_last_blk) begin
                        w_state = ST_DONE;
                    end else begin
                        w_blk   = r_blk + offset_t'(1);
                        w_state = bus.BG ? ST_FETCH : ST_REQ;
                    end
                end
            end
            ST_DONE: begin
                w_busy  = 1'b0;
                w_state = ST_IDLE;
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_base     <= '0;
            r_nblk     <= '0;
            r_blk      <= '0;
            r_buffer   <= '0;
            r_mem_addr <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_base     <= w_base;
            r_nblk     <= w_nblk;
            r_blk      <= w_blk;
            r_buffer   <= w_buffer;
            r_mem_addr <= w_mem_addr;
            r_busy     <= w_busy;
        end
    end

    assign bus.BR        = (r_state == ST_REQ) || (r_state == ST_FETCH) || (r_state == ST_WRITE);
    assign bus.offset    = (r_state == ST_FETCH) ? r_blk : IDLE_OFFSET;
    assign bus.mem_write = (r_state == ST_WRITE);
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_buffer;
    assign bus.busy      = r_busy;
    assign bus.dma_end   = (r_state == ST_DONE);

endmodule
